// File: rtl/micro_op_sequencer_if.sv
// Decode-to-rename handshake bundle for micro_op_sequencer: instruction in, issue slots out.
// The sequencer side takes the slave modport; the decode/dispatch side takes master.
interface micro_op_sequencer_if #(
  parameter int  ISSUE_WIDTH = 2,
  parameter int  CW          = $clog2(ISSUE_WIDTH + 1),
  parameter type ins_t       = logic,
  parameter type mop_t       = logic
);
  logic                   flush;
  logic                   ins_valid;
  logic                   ins_ready;
  ins_t                   ins;
  logic [CW-1:0]          out_credit;
  logic [0:ISSUE_WIDTH-1] mop_valid;
  mop_t                   mop [0:ISSUE_WIDTH-1];
  logic [0:ISSUE_WIDTH-1] mop_last;
  logic                   busy;

  modport master (
    output flush, ins_valid, ins, out_credit,
    input  ins_ready, mop_valid, mop, mop_last, busy
  );

  modport slave (
    input  flush, ins_valid, ins, out_credit,
    output ins_ready, mop_valid, mop, mop_last, busy
  );
endinterface

// File: rtl/micro_op_sequencer.sv
// Cracks decoded instructions into micro-ops and issues up to ISSUE_WIDTH per cycle.
// Latency: first op 1 cycle after accept (0 with MOP_SEQ_BYPASS_EN defined).
// Backpressure: per-cycle out_credit throttles issue; ins_ready rises only in IDLE or the final-issue cycle.
package micro_op_pkg;
  localparam int MAX_MOP_CNT = 6;
  localparam int CNT_W       = $clog2(MAX_MOP_CNT + 1);

  localparam logic [3:0] R_RAX    = 4'd0;
  localparam logic [3:0] R_RDX    = 4'd2;
  localparam logic [3:0] R_RSP    = 4'd4;
  localparam logic [3:0] R_TMP2   = 4'd13;
  localparam logic [3:0] R_TMP    = 4'd14;
  localparam logic [3:0] R_RFLAGS = 4'd15;

  typedef enum logic [2:0] {I_NOP, I_ADD_RR, I_MOV_RR, I_IMUL_M, I_SHL_M, I_RETQ} ins_op_e;
  typedef enum logic [3:0] {M_NONE, M_ADD, M_CPY, M_LEA, M_LD, M_ST,
                            M_IMUL_L, M_IMUL_H, M_SHL, M_JMP} uop_e;

  typedef struct packed {
    ins_op_e    opc;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] base;
  } fat_instruction_t;

  typedef struct packed {
    uop_e       op;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } micro_op_t;

  typedef struct packed {
    logic [CNT_W-1:0]             cnt;
    micro_op_t [MAX_MOP_CNT-1:0]  ops;
  } crack_t;

  function automatic micro_op_t mk(uop_e op, logic [3:0] dst, logic [3:0] a, logic [3:0] b);
    micro_op_t m;
    m.op    = op;
    m.dst   = dst;
    m.src_a = a;
    m.src_b = b;
    return m;
  endfunction

  function automatic crack_t gen_micro_ops(fat_instruction_t ins);
    crack_t c;
    c = '0;
    case (ins.opc)
      I_ADD_RR: begin
        c.cnt    = CNT_W'(2);
        c.ops[0] = mk(M_ADD, ins.rd, ins.rd, ins.rs);
        c.ops[1] = mk(M_CPY, R_RFLAGS, ins.rd, 4'd0);
      end
      I_MOV_RR: begin
        c.cnt    = CNT_W'(1);
        c.ops[0] = mk(M_CPY, ins.rd, ins.rs, 4'd0);
      end
      I_IMUL_M: begin
        c.cnt    = CNT_W'(6);
        c.ops[0] = mk(M_LEA, R_TMP, ins.base, 4'd0);
        c.ops[1] = mk(M_LD, R_TMP, R_TMP, 4'd0);
        c.ops[2] = mk(M_IMUL_L, R_TMP2, R_RAX, R_TMP);
        c.ops[3] = mk(M_IMUL_H, R_RDX, R_RAX, R_TMP);
        c.ops[4] = mk(M_CPY, R_RAX, R_TMP2, 4'd0);
        c.ops[5] = mk(M_CPY, R_RFLAGS, R_RDX, 4'd0);
      end
      I_SHL_M: begin
        c.cnt    = CNT_W'(5);
        c.ops[0] = mk(M_LEA, R_TMP, ins.base, 4'd0);
        c.ops[1] = mk(M_LD, R_TMP, R_TMP, 4'd0);
        c.ops[2] = mk(M_SHL, R_TMP, R_TMP, ins.rs);
        c.ops[3] = mk(M_ST, 4'd0, ins.base, R_TMP);
        c.ops[4] = mk(M_CPY, R_RFLAGS, R_TMP, 4'd0);
      end
      I_RETQ: begin
        c.cnt    = CNT_W'(3);
        c.ops[0] = mk(M_LD, R_TMP, R_RSP, 4'd0);
        c.ops[1] = mk(M_ADD, R_RSP, R_RSP, 4'd0);
        c.ops[2] = mk(M_JMP, 4'd0, R_TMP, 4'd0);
      end
      default: ;
    endcase
    return c;
  endfunction
endpackage

module micro_op_sequencer
  import micro_op_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int CW          = $clog2(ISSUE_WIDTH + 1)
) (
  input logic                 clk,
  input logic                 reset_n,
  micro_op_sequencer_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_e;

  localparam logic [CNT_W-1:0] IW = CNT_W'(ISSUE_WIDTH);

  state_e                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            idx_q;
  micro_op_t [MAX_MOP_CNT-1:0] mop_buf_q;

  logic [CNT_W-1:0]            credit, avail, n_buf, n_first;
  logic [CNT_W-1:0]            src_idx, src_cnt, src_n;
  micro_op_t [MAX_MOP_CNT-1:0] src_ops;
  crack_t                      crack;
  logic                        run, drain, accept, byp;

  function automatic logic [CNT_W-1:0] min_c(logic [CNT_W-1:0] a, logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign credit = (bus.out_credit > CW'(ISSUE_WIDTH)) ? IW : CNT_W'(bus.out_credit);
  assign run    = reset_n && !bus.flush;
  assign avail  = cnt_q - idx_q;
  // The remainder fits in this cycle's credit, so the next instruction may overlap.
  assign drain  = (state_q == ISSUE) && (avail <= credit);
  assign n_buf  = (run && state_q == ISSUE) ? min_c(avail, credit) : '0;

  assign bus.ins_ready = run && ((state_q == IDLE) || drain);
  assign accept        = bus.ins_valid && bus.ins_ready;
  assign crack         = gen_micro_ops(bus.ins);
  assign bus.busy      = reset_n && (state_q == ISSUE);

`ifdef MOP_SEQ_BYPASS_EN
  assign byp = accept && (state_q == IDLE);
`else
  assign byp = 1'b0;
`endif

  assign n_first = byp ? min_c(crack.cnt, credit) : '0;
  assign src_ops = byp ? crack.ops : mop_buf_q;
  assign src_idx = byp ? '0 : idx_q;
  assign src_cnt = byp ? crack.cnt : cnt_q;
  assign src_n   = byp ? n_first : n_buf;

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      bus.mop_valid[k] = (CNT_W'(k) < src_n);
      bus.mop[k]       = (CNT_W'(k) < src_n) ? src_ops[src_idx + CNT_W'(k)] : '0;
      bus.mop_last[k]  = (CNT_W'(k) < src_n) &&
                         ((src_idx + CNT_W'(k)) == (src_cnt - CNT_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      mop_buf_q <= '0;
    end else if (accept) begin
      mop_buf_q <= crack.ops;
      cnt_q     <= crack.cnt;
      idx_q     <= n_first;
      state_q   <= (crack.cnt == n_first) ? IDLE : ISSUE;
    end else if (state_q == ISSUE) begin
      idx_q <= idx_q + n_buf;
      if (drain) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_micro_op_sequencer.sv
// Random and directed stimulus for micro_op_sequencer against a queue-based model of pending micro-ops.
module tb_micro_op_sequencer;
  import micro_op_pkg::*;

  localparam int W  = 2;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  micro_op_sequencer_if #(.ISSUE_WIDTH(W), .CW(CW),
                          .ins_t(fat_instruction_t), .mop_t(micro_op_t)) bus ();

  micro_op_sequencer #(.ISSUE_WIDTH(W), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    micro_op_t op;
    logic      last;
  } exp_t;

  exp_t      pend [$];
  int        checks = 0;
  int        errors = 0;
  logic [0:W-1] s_valid, s_last;
  micro_op_t s_mop [W];
  logic      s_ready, s_busy;

  uop_e imul_seq [6] = '{M_LEA, M_LD, M_IMUL_L, M_IMUL_H, M_CPY, M_CPY};
  int   shl_cr   [5] = '{2, 0, 0, 1, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic micro_op_t u(uop_e o, int d, int a, int b);
    micro_op_t m;
    m.op = o; m.dst = 4'(d); m.src_a = 4'(a); m.src_b = 4'(b);
    return m;
  endfunction

  function automatic fat_instruction_t mkins(ins_op_e o, int rd, int rs, int base);
    fat_instruction_t f;
    f.opc = o; f.rd = 4'(rd); f.rs = 4'(rs); f.base = 4'(base);
    return f;
  endfunction

  // Expected micro-op lists per instruction kind, appended to the pending queue.
  task automatic push_ins(input fat_instruction_t i);
    micro_op_t s [$];
    exp_t      e;
    case (i.opc)
      I_ADD_RR: begin
        s.push_back(u(M_ADD, i.rd, i.rd, i.rs));
        s.push_back(u(M_CPY, R_RFLAGS, i.rd, 0));
      end
      I_MOV_RR: s.push_back(u(M_CPY, i.rd, i.rs, 0));
      I_IMUL_M: begin
        s.push_back(u(M_LEA, R_TMP, i.base, 0));
        s.push_back(u(M_LD, R_TMP, R_TMP, 0));
        s.push_back(u(M_IMUL_L, R_TMP2, R_RAX, R_TMP));
        s.push_back(u(M_IMUL_H, R_RDX, R_RAX, R_TMP));
        s.push_back(u(M_CPY, R_RAX, R_TMP2, 0));
        s.push_back(u(M_CPY, R_RFLAGS, R_RDX, 0));
      end
      I_SHL_M: begin
        s.push_back(u(M_LEA, R_TMP, i.base, 0));
        s.push_back(u(M_LD, R_TMP, R_TMP, 0));
        s.push_back(u(M_SHL, R_TMP, R_TMP, i.rs));
        s.push_back(u(M_ST, 0, i.base, R_TMP));
        s.push_back(u(M_CPY, R_RFLAGS, R_TMP, 0));
      end
      I_RETQ: begin
        s.push_back(u(M_LD, R_TMP, R_RSP, 0));
        s.push_back(u(M_ADD, R_RSP, R_RSP, 0));
        s.push_back(u(M_JMP, 0, R_TMP, 0));
      end
      default: ;
    endcase
    foreach (s[k]) begin
      e.op   = s[k];
      e.last = (k == s.size() - 1);
      pend.push_back(e);
    end
  endtask

  // One cycle: drive inputs after negedge, compare against the model, advance to next negedge.
  task automatic step(input logic rst, input logic fl, input logic v,
                      input fat_instruction_t i, input int cr);
    int c, n;
    bit acc, done;
    logic [0:W-1] ev, el;
    micro_op_t em [W];
    reset_n = rst; bus.flush = fl; bus.ins_valid = v; bus.ins = i; bus.out_credit = CW'(cr);
    #1;
    s_valid = bus.mop_valid; s_last = bus.mop_last;
    s_ready = bus.ins_ready; s_busy = bus.busy;
    for (int k = 0; k < W; k++) s_mop[k] = bus.mop[k];
    c  = (cr > W) ? W : cr;
    ev = '0; el = '0;
    for (int k = 0; k < W; k++) em[k] = '0;
    if (!rst) begin
      check("rst_ready", 32'(s_ready), 0);
      check("rst_busy", 32'(s_busy), 0);
      pend.delete();
    end else if (fl) begin
      check("flush_ready", 32'(s_ready), 0);
      check("busy", 32'(s_busy), 32'(pend.size() > 0));
      pend.delete();
    end else begin
      check("busy", 32'(s_busy), 32'(pend.size() > 0));
      check("ins_ready", 32'(s_ready), 32'(pend.size() <= c));
      acc  = v && (pend.size() <= c);
      done = 1'b0;
`ifdef MOP_SEQ_BYPASS_EN
      if (acc && pend.size() == 0) begin
        push_ins(i);
        done = 1'b1;
      end
`endif
      n = (pend.size() < c) ? pend.size() : c;
      for (int k = 0; k < n; k++) begin
        ev[k] = 1'b1;
        em[k] = pend[0].op;
        el[k] = pend[0].last;
        void'(pend.pop_front());
      end
      if (acc && !done) push_ins(i);
    end
    check("mop_valid", 32'(s_valid), 32'(ev));
    check("mop_last", 32'(s_last), 32'(el));
    for (int k = 0; k < W; k++) check("mop", 32'(s_mop[k]), 32'(em[k]));
    @(negedge clk);
  endtask

  initial begin
    fat_instruction_t ri;
    reset_n = 1'b0; bus.flush = 1'b0; bus.ins_valid = 1'b0; bus.ins = '0; bus.out_credit = '0;
    @(negedge clk);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, mkins(I_ADD_RR, 1, 2, 0), 2);
    check("ready_in_rst", 32'(s_ready), 0);
    step(1, 0, 0, '0, 2);
    check("ready_after_rst", 32'(s_ready), 1);
    check("busy_after_rst", 32'(s_busy), 0);

`ifndef MOP_SEQ_BYPASS_EN
    step(1, 0, 1, mkins(I_ADD_RR, 1, 3, 0), 2);
    check("add_accept_novld", 32'(s_valid), 0);
    step(1, 0, 0, '0, 2);
    check("add_slot0", 32'(s_mop[0].op), 32'(M_ADD));
    check("add_slot1", 32'(s_mop[1]), 32'(u(M_CPY, R_RFLAGS, 1, 0)));
    check("add_last", 32'(s_last), 32'(2'b01));
    check("add_ready", 32'(s_ready), 1);

    step(1, 0, 1, mkins(I_IMUL_M, 0, 0, 5), 1);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, '0, 1);
      check("imul_vld", 32'(s_valid), 32'(2'b10));
      check("imul_op", 32'(s_mop[0].op), 32'(imul_seq[k]));
      check("imul_last", 32'(s_last), (k == 5) ? 32'(2'b10) : 32'd0);
    end
    step(1, 0, 0, '0, 1);
    check("imul_busy_fall", 32'(s_busy), 0);

    step(1, 0, 1, mkins(I_NOP, 0, 0, 0), 2);
    check("nop_ready", 32'(s_ready), 1);
    step(1, 0, 1, mkins(I_MOV_RR, 2, 7, 0), 2);
    check("nop_no_slot", 32'(s_valid), 0);
    check("nop_ready_after", 32'(s_ready), 1);
    step(1, 0, 0, '0, 2);
    check("mov_op", 32'(s_mop[0]), 32'(u(M_CPY, 2, 7, 0)));
    check("mov_vld", 32'(s_valid), 32'(2'b10));
    check("mov_last", 32'(s_last), 32'(2'b10));

    step(1, 0, 1, mkins(I_SHL_M, 0, 1, 6), 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, '0, shl_cr[k]);
      check("shl_count", 32'($countones(s_valid)), 32'(shl_cr[k]));
      check("shl_last", 32'(s_last), (k == 4) ? 32'(2'b01) : 32'd0);
    end

    step(1, 0, 1, mkins(I_IMUL_M, 0, 0, 3), 2);
    step(1, 0, 0, '0, 2);
    check("pre_flush_vld", 32'(s_valid), 32'(2'b11));
    step(1, 1, 1, mkins(I_ADD_RR, 1, 2, 0), 2);
    check("flush_vld", 32'(s_valid), 0);
    check("flush_rdy", 32'(s_ready), 0);
    step(1, 0, 0, '0, 2);
    check("flush_busy", 32'(s_busy), 0);
    check("flush_after_vld", 32'(s_valid), 0);
`else
    step(1, 0, 1, mkins(I_RETQ, 0, 0, 0), 2);
    check("retq_op0", 32'(s_mop[0].op), 32'(M_LD));
    check("retq_op1", 32'(s_mop[1].op), 32'(M_ADD));
    check("retq_vld", 32'(s_valid), 32'(2'b11));
    check("retq_last0", 32'(s_last), 0);
    step(1, 0, 0, '0, 2);
    check("retq_op2", 32'(s_mop[0].op), 32'(M_JMP));
    check("retq_last1", 32'(s_last), 32'(2'b10));
`endif

    step(1, 0, 1, mkins(I_IMUL_M, 0, 0, 9), 1);
    step(1, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    check("rst_mid_vld", 32'(s_valid), 0);
    step(1, 0, 0, '0, 2);
    check("rst_mid_busy", 32'(s_busy), 0);
    check("rst_mid_after_vld", 32'(s_valid), 0);

    for (int it = 0; it < 3000; it++) begin
      ri = mkins(ins_op_e'($urandom_range(0, 5)), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 60), ri, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
